// File: rtl/out_deser_pkg.sv
//------------------------------------------------------------------------------
// Module : out_deser_pkg
// Brief  : Shared FSM state type and default sizing for the serial deserializer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package out_deser_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int c_word_w_default     = 8;
    localparam int c_fifo_depth_default = 4;

endpackage

`default_nettype wire

// File: rtl/out_deser_fifo.sv
//------------------------------------------------------------------------------
// Module : out_deser_fifo
// Brief  : Word FIFO with wrap-bit pointers; a pop frees a full slot same edge.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module out_deser_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_push,
    input  logic [DATA_W-1:0]         i_push_data,
    input  logic                      i_pop,
    output logic [DATA_W-1:0]         o_rd_data,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0]       r_wr_ptr;
    logic [c_aw:0]       r_rd_ptr;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_do_push;
    logic                w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]) &&
                       (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage is not reset, so the head is forced to zero while empty.
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= i_push_data;
    end

endmodule

`default_nettype wire

// File: rtl/out_deser.sv
//------------------------------------------------------------------------------
// Module : out_deser
// Brief  : LSB-first serial-to-word deserializer feeding a word FIFO.
//          Optional OUT_DESER_PARITY_EN adds a stored word_parity output.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module out_deser
    import out_deser_pkg::*;
#(
    parameter int WORD_W     = c_word_w_default,
    parameter int FIFO_DEPTH = c_fifo_depth_default
) (
    input  logic                          tau2015_clk,
    input  logic                          tau2015_rst_n,
    input  logic                          ser_in,
    input  logic                          en,
    output logic [WORD_W-1:0]             word_data,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
`ifdef OUT_DESER_PARITY_EN
    ,
    output logic                          word_parity
`endif
);

    localparam int                 c_cnt_w    = $clog2(WORD_W);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WORD_W - 1);
`ifdef OUT_DESER_PARITY_EN
    localparam int                 c_data_w   = WORD_W + 1;
`else
    localparam int                 c_data_w   = WORD_W;
`endif

    state_t               r_state;
    state_t               w_next_state;
    logic [c_cnt_w-1:0]   r_bit_cnt;
    logic [WORD_W-1:0]    r_shift;
    logic [WORD_W-1:0]    w_word;
    logic                 w_sample;
    logic                 w_complete;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 r_overflow;
    logic [c_data_w-1:0]  w_fifo_in;
    logic [c_data_w-1:0]  w_fifo_out;

    always_ff @(posedge tau2015_clk) begin
        if (!tau2015_rst_n) r_state <= IDLE;
        else                r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (en) w_next_state = COLLECT;
            COLLECT: if (en && (r_bit_cnt == c_last_bit)) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_sample   = en;
        w_complete = en && (r_state == COLLECT) && (r_bit_cnt == c_last_bit);
    end

    // In IDLE the count is zero, so one indexed write covers both states.
    always_ff @(posedge tau2015_clk) begin
        if (!tau2015_rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_complete) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_sample) begin
            r_shift[r_bit_cnt] <= ser_in;
            r_bit_cnt          <= r_bit_cnt + 1'b1;
        end
    end

    always_comb begin
        w_word             = r_shift;
        w_word[WORD_W-1]   = ser_in;
    end

    assign w_pop      = word_ready & ~w_empty;
    assign word_valid = ~w_empty;
    assign overflow   = r_overflow;

    always_ff @(posedge tau2015_clk) begin
        if (!tau2015_rst_n)                      r_overflow <= 1'b0;
        else if (w_complete && w_full && !w_pop) r_overflow <= 1'b1;
    end

`ifdef OUT_DESER_PARITY_EN
    assign w_fifo_in   = {^w_word, w_word};
    assign word_parity = w_fifo_out[WORD_W];
`else
    assign w_fifo_in   = w_word;
`endif
    assign word_data   = w_fifo_out[WORD_W-1:0];

    out_deser_fifo #(
        .DATA_W (c_data_w),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (tau2015_clk),
        .rst_n       (tau2015_rst_n),
        .i_push      (w_complete),
        .i_push_data (w_fifo_in),
        .i_pop       (w_pop),
        .o_rd_data   (w_fifo_out),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (fifo_count)
    );

endmodule

`default_nettype wire
